// File: rtl/objects_mux_pkg.sv
// Shared types, defaults and the priority encoder for the layered object mux.
package objects_mux_pkg;

  localparam int          DEF_RGB_W     = 8;
  localparam logic [7:0]  DEF_KEY_COLOR = 8'hFF;
  localparam int          MAX_LAYERS    = 16;
  localparam int          IDX_W         = $clog2(MAX_LAYERS);

  typedef logic [DEF_RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } prio_t;

  // Lowest set bit wins; scanning downward lets later hits overwrite earlier ones.
  function automatic prio_t priority_index(input logic [MAX_LAYERS-1:0] req);
    prio_t res;
    res = '0;
    for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        res.found = 1'b1;
        res.index = IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/objects_mux_collision.sv
// Per-frame collision accumulator; publishes the closing frame's overlap set on startOfFrame.
module objects_mux_collision #(
  parameter int NUM_LAYERS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic                  valid,
  input  logic [NUM_LAYERS-1:0] req,
  output logic [NUM_LAYERS-1:0] collision_mask,
  output logic                  collision_any
);

  logic [NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS-1:0] hits;
  logic [NUM_LAYERS-1:0] closing;

  // Two or more bits set <=> clearing the lowest set bit leaves something behind.
  always_comb begin
    hits = '0;
    if (valid && ((req & (req - NUM_LAYERS'(1))) != '0)) hits = req;
    closing = acc | hits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      collision_mask <= '0;
      collision_any  <= 1'b0;
    end else if (sof) begin
      collision_mask <= closing;
      collision_any  <= |closing;
      acc            <= '0;
    end else begin
      acc <= closing;
    end
  end

endmodule

// File: rtl/objects_mux_layered.sv
// N-layer priority pixel mux (layer 0 on top) with frame-synchronous layer mask and
// collision reporting. Define OBJMUX_COLOR_KEY_EN to treat KEY_COLOR pixels as transparent.
module objects_mux_layered
  import objects_mux_pkg::*;
#(
  parameter int               NUM_LAYERS = 4,
  parameter int               RGB_W      = DEF_RGB_W,
  parameter logic [RGB_W-1:0] KEY_COLOR  = RGB_W'(DEF_KEY_COLOR)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic [NUM_LAYERS-1:0]       drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            fallbackRGB,
  input  logic                        pixelValid,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       cfgMask,
  input  logic                        cfgWr,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [NUM_LAYERS-1:0]       collisionMask,
  output logic                        collisionAny
);

`ifdef OBJMUX_COLOR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [NUM_LAYERS-1:0]       shadow_mask;
  logic [NUM_LAYERS-1:0]       active_mask;
  logic [NUM_LAYERS-1:0]       req_eff;
  logic [NUM_LAYERS-1:0]       req_s1;
  logic                        valid_s1;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_s1;
  logic [RGB_W-1:0]            fallback_s1;
  prio_t                       win;
  logic [RGB_W-1:0]            win_rgb;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_eff = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      req_eff[i] = drawReq[i] & active_mask[i]
                 & !(KEY_EN && (layerRGB[i*RGB_W +: RGB_W] == KEY_COLOR));
    end
  end

  // A same-cycle write and frame start hands the new mask straight to the active copy.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow_mask <= '1;
      active_mask <= '1;
    end else begin
      if (cfgWr)        shadow_mask <= cfgMask;
      if (startOfFrame) active_mask <= cfgWr ? cfgMask : shadow_mask;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      req_s1   <= '0;
      valid_s1 <= 1'b0;
    end else begin
      req_s1   <= req_eff;
      valid_s1 <= pixelValid;
    end
  end

  // NOTE: pure datapath registers carry no reset; valid_s1 gates them until they hold real data.
  always_ff @(posedge clk) begin
    rgb_s1      <= layerRGB;
    fallback_s1 <= fallbackRGB;
  end

  always_comb begin
    win     = priority_index(MAX_LAYERS'(req_s1));
    win_rgb = rgb_s1[int'(win.index)*RGB_W +: RGB_W];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)        RGBOut <= '0;
    else if (!valid_s1) RGBOut <= '0;
    else if (win.found) RGBOut <= win_rgb;
    else                RGBOut <= fallback_s1;
  end

  objects_mux_collision #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_collision (
    .clk            (clk),
    .rst_n          (resetN),
    .sof            (startOfFrame),
    .valid          (valid_s1),
    .req            (req_s1),
    .collision_mask (collisionMask),
    .collision_any  (collisionAny)
  );

endmodule

// File: tb/tb_objects_mux_layered.sv
// Directed bench for objects_mux_layered: priority, blanking, mask timing, collisions, reset, colour key.
module tb_objects_mux_layered;
  import objects_mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           resetN;
  logic [N-1:0]   drawReq;
  logic [N*W-1:0] layerRGB;
  rgb_t           fallbackRGB;
  logic           pixelValid;
  logic           startOfFrame;
  logic [N-1:0]   cfgMask;
  logic           cfgWr;
  rgb_t           RGBOut;
  logic [N-1:0]   collisionMask;
  logic           collisionAny;

  int total  = 0;
  int passed = 0;

  objects_mux_layered #(.NUM_LAYERS(N), .RGB_W(W), .KEY_COLOR(8'hFF)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .drawReq       (drawReq),
    .layerRGB      (layerRGB),
    .fallbackRGB   (fallbackRGB),
    .pixelValid    (pixelValid),
    .startOfFrame  (startOfFrame),
    .cfgMask       (cfgMask),
    .cfgWr         (cfgWr),
    .RGBOut        (RGBOut),
    .collisionMask (collisionMask),
    .collisionAny  (collisionAny)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input logic [N-1:0] req, input logic v);
    drawReq    = req;
    pixelValid = v;
  endtask

  task automatic frame_start();
    startOfFrame = 1'b1;
    cycle(1);
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; pix('0, 1'b0);
    startOfFrame = 1'b0; cfgWr = 1'b0; cfgMask = 4'hF;
    layerRGB = {8'h33, 8'hE0, 8'h1C, 8'h11};
    fallbackRGB = 8'h25;
    cycle(2);
    total++; if (RGBOut !== 8'h00) $display("FAIL reset_rgb: got %h exp %h", RGBOut, 8'h00); else passed++;
    total++; if (collisionMask !== 4'b0000) $display("FAIL reset_cmask: got %b exp %b", collisionMask, 4'b0000); else passed++;
    total++; if (collisionAny !== 1'b0) $display("FAIL reset_cany: got %b exp %b", collisionAny, 1'b0); else passed++;
    #2 resetN = 1'b1;
    cycle(1);
  endtask

  task automatic test_priority();
    pix(4'b0110, 1'b1);
    cycle(1);
    total++; if (RGBOut !== 8'h00) $display("FAIL prio_latency1: got %h exp %h", RGBOut, 8'h00); else passed++;
    cycle(1);
    total++; if (RGBOut !== 8'h1C) $display("FAIL prio_rgb: got %h exp %h", RGBOut, 8'h1C); else passed++;
    pix('0, 1'b0);
    frame_start();
    total++; if (collisionMask !== 4'b0110) $display("FAIL prio_cmask: got %b exp %b", collisionMask, 4'b0110); else passed++;
    total++; if (collisionAny !== 1'b1) $display("FAIL prio_cany: got %b exp %b", collisionAny, 1'b1); else passed++;
  endtask

  task automatic test_empty();
    pix('0, 1'b1);
    cycle(2);
    total++; if (RGBOut !== 8'h25) $display("FAIL empty_fallback: got %h exp %h", RGBOut, 8'h25); else passed++;
    pix('0, 1'b0);
    cycle(2);
    total++; if (RGBOut !== 8'h00) $display("FAIL empty_blank: got %h exp %h", RGBOut, 8'h00); else passed++;
    total++; if (collisionMask !== 4'b0110) $display("FAIL empty_cmask_hold: got %b exp %b", collisionMask, 4'b0110); else passed++;
    frame_start();
    total++; if (collisionMask !== 4'b0000) $display("FAIL empty_cmask: got %b exp %b", collisionMask, 4'b0000); else passed++;
    total++; if (collisionAny !== 1'b0) $display("FAIL empty_cany: got %b exp %b", collisionAny, 1'b0); else passed++;
  endtask

  task automatic test_mask_timing();
    pix(4'b0011, 1'b1);
    cfgMask = 4'b1110; cfgWr = 1'b1;
    cycle(1);
    cfgWr = 1'b0;
    cycle(1);
    total++; if (RGBOut !== 8'h11) $display("FAIL mask_l0_before: got %h exp %h", RGBOut, 8'h11); else passed++;
    cycle(1);
    total++; if (RGBOut !== 8'h11) $display("FAIL mask_l0_midframe: got %h exp %h", RGBOut, 8'h11); else passed++;
    pix(4'b0011, 1'b0);
    frame_start();
    total++; if (collisionMask !== 4'b0011) $display("FAIL mask_cmask: got %b exp %b", collisionMask, 4'b0011); else passed++;
    pix(4'b0011, 1'b1);
    cycle(1);
    total++; if (RGBOut !== 8'h00) $display("FAIL mask_sof_blank: got %h exp %h", RGBOut, 8'h00); else passed++;
    cycle(1);
    total++; if (RGBOut !== 8'h1C) $display("FAIL mask_l1_after: got %h exp %h", RGBOut, 8'h1C); else passed++;
  endtask

  task automatic test_same_cycle();
    pix(4'b1111, 1'b0);
    cfgMask = 4'b0001; cfgWr = 1'b1;
    frame_start();
    cfgWr = 1'b0; cfgMask = 4'hF;
    total++; if (collisionMask !== 4'b0000) $display("FAIL same_cmask: got %b exp %b", collisionMask, 4'b0000); else passed++;
    pix(4'b1111, 1'b1);
    cycle(2);
    total++; if (RGBOut !== 8'h11) $display("FAIL same_l0: got %h exp %h", RGBOut, 8'h11); else passed++;
    pix(4'b1110, 1'b1);
    cycle(2);
    total++; if (RGBOut !== 8'h25) $display("FAIL same_masked_fallback: got %h exp %h", RGBOut, 8'h25); else passed++;
    pix('0, 1'b0);
    cfgMask = 4'hF; cfgWr = 1'b1;
    frame_start();
    cfgWr = 1'b0;
    total++; if (collisionMask !== 4'b0000) $display("FAIL same_disabled_nocoll: got %b exp %b", collisionMask, 4'b0000); else passed++;
    total++; if (collisionAny !== 1'b0) $display("FAIL same_disabled_cany: got %b exp %b", collisionAny, 1'b0); else passed++;
  endtask

  task automatic test_collision();
    pix(4'b1001, 1'b1);
    cycle(5);
    pix('0, 1'b0);
    frame_start();
    total++; if (collisionMask !== 4'b1001) $display("FAIL coll_cmask: got %b exp %b", collisionMask, 4'b1001); else passed++;
    total++; if (collisionAny !== 1'b1) $display("FAIL coll_cany: got %b exp %b", collisionAny, 1'b1); else passed++;
    pix(4'b0100, 1'b1);
    cycle(4);
    total++; if (collisionMask !== 4'b1001) $display("FAIL coll_hold: got %b exp %b", collisionMask, 4'b1001); else passed++;
    pix('0, 1'b0);
    frame_start();
    total++; if (collisionMask !== 4'b0000) $display("FAIL coll_clear: got %b exp %b", collisionMask, 4'b0000); else passed++;
    total++; if (collisionAny !== 1'b0) $display("FAIL coll_clear_any: got %b exp %b", collisionAny, 1'b0); else passed++;
    pix(4'b0110, 1'b1);
    cycle(2);
    pix('0, 1'b0);
    frame_start();
    total++; if (collisionMask !== 4'b0110) $display("FAIL dbl_first: got %b exp %b", collisionMask, 4'b0110); else passed++;
    cycle(1);
    frame_start();
    total++; if (collisionMask !== 4'b0000) $display("FAIL dbl_second: got %b exp %b", collisionMask, 4'b0000); else passed++;
    total++; if (collisionAny !== 1'b0) $display("FAIL dbl_second_any: got %b exp %b", collisionAny, 1'b0); else passed++;
  endtask

  task automatic test_reset_mid();
    pix(4'b1001, 1'b1);
    cycle(3);
    cfgMask = 4'b0001; cfgWr = 1'b1;
    frame_start();
    cfgWr = 1'b0; cfgMask = 4'hF;
    cycle(2);
    total++; if (collisionMask !== 4'b1001) $display("FAIL rmid_pre_cmask: got %b exp %b", collisionMask, 4'b1001); else passed++;
    resetN = 1'b0;
    #1;
    total++; if (RGBOut !== 8'h00) $display("FAIL rmid_rgb: got %h exp %h", RGBOut, 8'h00); else passed++;
    total++; if (collisionMask !== 4'b0000) $display("FAIL rmid_cmask: got %b exp %b", collisionMask, 4'b0000); else passed++;
    total++; if (collisionAny !== 1'b0) $display("FAIL rmid_cany: got %b exp %b", collisionAny, 1'b0); else passed++;
    pix('0, 1'b0);
    #2 resetN = 1'b1;
    cycle(1);
    pix(4'b1000, 1'b1);
    cycle(2);
    total++; if (RGBOut !== 8'h33) $display("FAIL rmid_mask_ones: got %h exp %h", RGBOut, 8'h33); else passed++;
    pix('0, 1'b0);
    frame_start();
    total++; if (collisionMask !== 4'b0000) $display("FAIL rmid_first_sof: got %b exp %b", collisionMask, 4'b0000); else passed++;
  endtask

  task automatic test_color_key();
    rgb_t         exp_rgb;
    logic [N-1:0] exp_cm;
`ifdef OBJMUX_COLOR_KEY_EN
    exp_rgb = 8'h1C; exp_cm = 4'b0000;
`else
    exp_rgb = 8'hFF; exp_cm = 4'b0011;
`endif
    layerRGB = {8'h33, 8'hE0, 8'h1C, 8'hFF};
    pix(4'b0011, 1'b1);
    cycle(2);
    total++; if (RGBOut !== exp_rgb) $display("FAIL key_rgb: got %h exp %h", RGBOut, exp_rgb); else passed++;
    pix('0, 1'b0);
    frame_start();
    total++; if (collisionMask !== exp_cm) $display("FAIL key_cmask: got %b exp %b", collisionMask, exp_cm); else passed++;
    total++; if (collisionAny !== (|exp_cm)) $display("FAIL key_cany: got %b exp %b", collisionAny, |exp_cm); else passed++;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_empty();
    test_mask_timing();
    test_same_cycle();
    test_collision();
    test_reset_mid();
    test_color_key();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
